id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage: multi-read-port register file with write-back bypass,
//  destination select, immediate extension and a registered ID/EX output slot.
//  Uses a valid/ready handshake. Sits between the IF and EX stages.
//  A post-reset sweep clears every register. Register 0 reads as zero.
// PARAMETERS
//  XLEN     32  data width of registers, Wdata, Rdata*, Ed32
//  REG_NUM  32  number of architectural registers (power of 2, >=2); AW=$clog2(REG_NUM)
//  BYPASS   1   1: same-cycle write-back forwarded to read ports; 0: read old value
// PORTS
//  CLK       in   1     clock, rising edge
//  RST_N     in   1     reset, asynchronous, active-low
//  in_valid  in   1     Ins is valid
//  in_ready  out  1     stage accepts Ins this cycle
//  Ins       in   32    instruction word (MIPS fields op/rs/rt/rd/imm)
//  wb_en     in   1     write-back enable
//  wb_addr   in   AW    write-back register index
//  Wdata     in   XLEN  write-back data
//  out_valid out  1     ID/EX slot holds a decoded instruction
//  out_ready in   1     EX consumes slot this cycle
//  Rdata1    out  XLEN  registered value of rs
//  Rdata2    out  XLEN  registered value of rt
//  Ed32      out  XLEN  registered extended immediate
//  Wadr      out  AW    registered destination index
//  reg_we    out  1     registered: instruction writes a register
//  init_busy out  1     clear sweep in progress
// BEHAVIOUR
//  Reset (RST_N=0): all outputs 0, except init_busy=1. FSM enters CLEAR with idx=1.
//   Array contents are not reset directly.
//  FSM CLEAR: writes REG_FILE[idx]<=0 each cycle; idx++. After idx==REG_NUM-1, go to RUN.
//   Duration: REG_NUM-1 cycles. in_ready=0; wb_en ignored; init_busy=1.
//  FSM RUN: init_busy=0. in_ready = !out_valid | out_ready.
//   Reset asserted mid-sweep restarts CLEAR at idx=1.
//  Write: in RUN, if wb_en and wb_addr!=0, REG_FILE[wb_addr]<=Wdata on the edge.
//   Writes to index 0 are dropped; a read of index 0 always returns 0.
//  Read: comb rs=Ins[25:21], rt=Ins[20:16]; index truncated to the low AW bits.
//   If BYPASS and wb_en and wb_addr==idx and idx!=0, the read returns Wdata; else REG_FILE[idx].
//  Dest: op==JAL -> REG_NUM-1; op==R_FORM -> rd; else rt.
//   we = !(op==SW | op==BEQ | op==J) & dest!=0.
//  Ext: op in {ANDI,ORI,XORI} -> zero-extend Ins[15:0]; else sign-extend Ins[15] to XLEN.
//  Handshake: when in_valid & in_ready, the slot loads rd1/rd2/ext/dest/we and out_valid<=1.
//   Else if out_ready, out_valid<=0. If out_valid & !out_ready, the slot holds all fields stable.
//   Latency is 1 cycle from accept to out_valid.
//  Simultaneous load and consume: the new entry replaces the old one; out_valid stays 1.
//   No bubble is inserted.
//  Hazard: a write-back to an rs/rt held in a stalled slot does NOT update the slot.
//   The producer/hazard unit owns that case.
// STRUCTURE
//  Shared package mips_pkg: opcode constants R_FORM=6'h00, J=6'h02, JAL=6'h03, BEQ=6'h04,
//   ANDI=6'h0C, ORI=6'h0D, XORI=6'h0E, SW=6'h2B.
//   The package also holds the FSM state enum {CLEAR,RUN}.
//  One sub-module: id_regfile (array, 2 read ports, 1 write port, zero reg, bypass,
//   clear port). Decode, extension, FSM and output slot live in id_stage_pipe.
// TESTING
//  1 Reset, then hold RST_N=1 for 31 cycles: init_busy=1 and in_ready=0 throughout.
//   Cycle 32: init_busy=0; every register reads 0.
//  2 Write Wdata=32'hDEAD_BEEF to addr 9, then issue R-form rs=9 with wb_en (addr 9, data 5)
//   in the same cycle. BYPASS=1: Rdata1=5. BYPASS=0: Rdata1=32'hDEAD_BEEF.
//  3 Write to addr 0 with Wdata=7; then read rs=0 -> Rdata1=0.
//   JAL -> Wadr=31, reg_we=1. SW/BEQ -> reg_we=0.
//  4 ORI imm=16'h8001 -> Ed32=32'h0000_8001. ADDI imm=16'h8001 -> Ed32=32'hFFFF_8001.
//  5 out_ready=0 for 3 cycles with in_valid=1: in_ready=0 and outputs stay stable.
//   Then out_ready=1 with in_valid=1: back-to-back accepts, no bubble.
//  6 Drop RST_N at cycle 10 of the sweep: outputs clear immediately.
//   On release the full 31-cycle sweep repeats.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode constants and the decode-stage FSM state type.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mips_pkg;

  // Opcode field values (Ins[31:26]) that the decode stage cares about.
  localparam logic [5:0] R_FORM = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] SW     = 6'h2B;

  // CLEAR: post-reset sweep zeroing the register file; RUN: normal decode.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } id_state_e;

  // Logical immediates are zero-extended; everything else is sign-extended.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == ANDI) || (op == ORI) || (op == XORI);
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: 2 combinational read ports, 1 write port, clear port, r0 hard zero.
// Latency: reads combinational (optional same-cycle write bypass); writes land on the edge.
// Backpressure: none; the clear port has priority over the write port.
module id_regfile #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic            CLK,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   clr_idx_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  // Entry 0 is never written; reads of index 0 are forced to zero below.
  logic [XLEN-1:0] mem_q [REG_NUM];
  logic            hit1;
  logic            hit2;

  // Sweep clear wins; otherwise a write-back to a non-zero index updates the array.
  always_ff @(posedge CLK) begin
    if (clr_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Forward the in-flight write-back so the decoded operand is never one write stale.
  assign hit1 = (BYPASS != 0) && we_i && (waddr_i == raddr1_i);
  assign hit2 = (BYPASS != 0) && we_i && (waddr_i == raddr2_i);

  assign rdata1_o = (raddr1_i == '0) ? '0 : (hit1 ? wdata_i : mem_q[raddr1_i]);
  assign rdata2_o = (raddr2_i == '0) ? '0 : (hit2 ? wdata_i : mem_q[raddr2_i]);

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register read with write-back bypass, dest/imm decode, registered ID/EX slot.
// Latency: 1 cycle accept-to-out_valid; REG_NUM-1 cycle clear sweep after every reset.
// Backpressure: in_ready drops while the slot is full and EX is not consuming (and during sweep).
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Ins,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] Wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Rdata1,
  output logic [XLEN-1:0] Rdata2,
  output logic [XLEN-1:0] Ed32,
  output logic [AW-1:0]   Wadr,
  output logic            reg_we,
  output logic            init_busy
);

  id_state_e       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clr;
  logic            run;

  logic [5:0]      op;
  logic [AW-1:0]   rs_idx, rt_idx, rd_idx;
  logic [AW-1:0]   dest;
  logic            we_dec;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] rd1, rd2;
  logic            accept;

  logic            vld_q;
  logic [XLEN-1:0] rd1_q, rd2_q, ext_q;
  logic [AW-1:0]   wadr_q;
  logic            we_q;

  // Sweep state register; reset restarts the sweep at index 1 (index 0 is hard zero).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= CLEAR;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Walk the clear index to the last register, then hand over to normal decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    run     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr   = 1'b1;
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(REG_NUM - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Field extraction; register indices keep only the low AW bits of the 5-bit fields.
  always_comb begin
    op     = Ins[31:26];
    rs_idx = AW'(Ins[25:21]);
    rt_idx = AW'(Ins[20:16]);
    rd_idx = AW'(Ins[15:11]);
  end

  // Destination select, write-enable and immediate extension.
  always_comb begin
    dest = rt_idx;
    if (op == JAL) begin
      dest = AW'(REG_NUM - 1);
    end else if (op == R_FORM) begin
      dest = rd_idx;
    end
    we_dec = !((op == SW) || (op == BEQ) || (op == J)) && (dest != '0);
    if (is_logic_imm(op)) begin
      ext = {{(XLEN-16){1'b0}}, Ins[15:0]};
    end else begin
      ext = {{(XLEN-16){Ins[15]}}, Ins[15:0]};
    end
  end

  id_regfile #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM),
    .BYPASS  (BYPASS)
  ) u_regfile (
    .CLK       (CLK),
    .we_i      (run && wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (Wdata),
    .clr_i     (clr),
    .clr_idx_i (idx_q),
    .raddr1_i  (rs_idx),
    .raddr2_i  (rt_idx),
    .rdata1_o  (rd1),
    .rdata2_o  (rd2)
  );

  // Handshake: accept only in RUN when the slot is empty or being drained this cycle.
  always_comb begin
    in_ready  = run && (!vld_q || out_ready);
    init_busy = !run;
    accept    = in_valid && in_ready;
  end

  // ID/EX slot: load on accept (replacing any consumed entry), else drop valid when consumed.
  // A stalled slot is never refreshed by later write-backs; hazard handling lives upstream.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q  <= 1'b0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      ext_q  <= '0;
      wadr_q <= '0;
      we_q   <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      rd1_q  <= rd1;
      rd2_q  <= rd2;
      ext_q  <= ext;
      wadr_q <= dest;
      we_q   <= we_dec;
    end else if (out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign Rdata1    = rd1_q;
  assign Rdata2    = rd2_q;
  assign Ed32      = ext_q;
  assign Wadr      = wadr_q;
  assign reg_we    = we_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: BYPASS=1 and BYPASS=0 instances share stimulus.
// Latency: n/a (testbench).
// Backpressure: driven directly via out_ready.
module tb_id_stage_pipe;
  import mips_pkg::*;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int AW      = 5;
  localparam logic [5:0] OP_ADDI = 6'h08;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            in_valid = 1'b0;
  logic [31:0]     Ins = '0;
  logic            wb_en = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [XLEN-1:0] Wdata = '0;
  logic            out_ready = 1'b0;

  logic            in_ready, out_valid, reg_we, init_busy;
  logic [XLEN-1:0] Rdata1, Rdata2, Ed32;
  logic [AW-1:0]   Wadr;
  logic            nb_in_ready, nb_out_valid, nb_reg_we, nb_init_busy;
  logic [XLEN-1:0] nb_Rdata1, nb_Rdata2, nb_Ed32;
  logic [AW-1:0]   nb_Wadr;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  id_stage_pipe #(.XLEN(XLEN), .REG_NUM(REG_NUM), .BYPASS(1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .Ins(Ins),
    .wb_en(wb_en), .wb_addr(wb_addr), .Wdata(Wdata), .out_valid(out_valid),
    .out_ready(out_ready), .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32),
    .Wadr(Wadr), .reg_we(reg_we), .init_busy(init_busy)
  );

  id_stage_pipe #(.XLEN(XLEN), .REG_NUM(REG_NUM), .BYPASS(0)) u_nb (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(nb_in_ready), .Ins(Ins),
    .wb_en(wb_en), .wb_addr(wb_addr), .Wdata(Wdata), .out_valid(nb_out_valid),
    .out_ready(out_ready), .Rdata1(nb_Rdata1), .Rdata2(nb_Rdata2), .Ed32(nb_Ed32),
    .Wadr(nb_Wadr), .reg_we(nb_reg_we), .init_busy(nb_init_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_sweep = REG_NUM - 1;
  logic [31:0] m_regs [REG_NUM];
  logic        m_valid = 1'b0;
  logic [31:0] m_rd1 = '0, m_rd2 = '0, m_rd1n = '0, m_rd2n = '0, m_ext = '0;
  logic [4:0]  m_wadr = '0;
  logic        m_we = 1'b0;

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wb_en && (wb_addr == a)) return Wdata;
    return m_regs[a];
  endfunction

  function automatic logic [4:0] mdest(input logic [31:0] ins);
    if (ins[31:26] == JAL) return 5'd31;
    if (ins[31:26] == R_FORM) return ins[15:11];
    return ins[20:16];
  endfunction

  function automatic logic mwe(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    if (op == SW || op == BEQ || op == J) return 1'b0;
    return mdest(ins) != 5'd0;
  endfunction

  function automatic logic [31:0] mext(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    if (op == ANDI || op == ORI || op == XORI) return {16'h0000, ins[15:0]};
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  // Reset zeroes everything at once: nothing reads the file until the sweep time has elapsed.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_sweep = REG_NUM - 1;
      m_valid = 1'b0;
      m_rd1 = '0; m_rd2 = '0; m_rd1n = '0; m_rd2n = '0; m_ext = '0;
      m_wadr = '0; m_we = 1'b0;
      for (int i = 0; i < REG_NUM; i++) m_regs[i] = '0;
    end else if (m_sweep > 0) begin
      m_sweep = m_sweep - 1;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid = 1'b1;
        m_rd1  = mread(Ins[25:21], 1'b1);
        m_rd2  = mread(Ins[20:16], 1'b1);
        m_rd1n = mread(Ins[25:21], 1'b0);
        m_rd2n = mread(Ins[20:16], 1'b0);
        m_ext  = mext(Ins);
        m_wadr = mdest(Ins);
        m_we   = mwe(Ins);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = Wdata;
    end
  end

  // Compare both instances to the model every cycle.
  always @(negedge CLK) begin
    logic exp_rdy;
    exp_rdy = (m_sweep == 0) && (!m_valid || out_ready);
    chk("m_busy",     32'(init_busy),    32'(m_sweep != 0));
    chk("m_in_ready", 32'(in_ready),     32'(exp_rdy));
    chk("m_valid",    32'(out_valid),    32'(m_valid));
    chk("m_rdata1",   Rdata1,            m_rd1);
    chk("m_rdata2",   Rdata2,            m_rd2);
    chk("m_ed32",     Ed32,              m_ext);
    chk("m_wadr",     32'(Wadr),         32'(m_wadr));
    chk("m_reg_we",   32'(reg_we),       32'(m_we));
    chk("nb_busy",    32'(nb_init_busy), 32'(m_sweep != 0));
    chk("nb_in_ready",32'(nb_in_ready),  32'(exp_rdy));
    chk("nb_valid",   32'(nb_out_valid), 32'(m_valid));
    chk("nb_rdata1",  nb_Rdata1,         m_rd1n);
    chk("nb_rdata2",  nb_Rdata2,         m_rd2n);
    chk("nb_ed32",    nb_Ed32,           m_ext);
    chk("nb_wadr",    32'(nb_Wadr),      32'(m_wadr));
    chk("nb_reg_we",  32'(nb_reg_we),    32'(m_we));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd);
    return {R_FORM, 5'(rs), 5'(rt), 5'(rd), 11'h000};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic sweep_check(input string tag);
    for (int i = 0; i < REG_NUM - 1; i++) begin
      chk({tag, "_busy"},  32'(init_busy), 32'd1);
      chk({tag, "_rdy"},   32'(in_ready),  32'd0);
      cyc();
    end
    chk({tag, "_done"}, 32'(init_busy), 32'd0);
  endtask

  task automatic read_all_zero(input string tag);
    out_ready = 1'b1;
    wb_en     = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      in_valid = 1'b1;
      Ins      = mk_r(i, REG_NUM - 1 - i, 1);
      cyc();
      chk({tag, "_rd1"}, Rdata1, 32'd0);
      chk({tag, "_rd2"}, Rdata2, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset and sweep; a write-back held high during the sweep must be ignored.
    wb_en = 1'b1; wb_addr = 5'd3; Wdata = 32'h0000_00AA;
    in_valid = 1'b1; Ins = mk_r(3, 3, 4);
    repeat (3) cyc();
    chk("rst_busy",  32'(init_busy), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rdata", Rdata1,         32'd0);
    RST_N = 1'b1;
    sweep_check("sweep1");
    in_valid = 1'b0; wb_en = 1'b0;
    read_all_zero("zero1");

    // 2: same-cycle write-back bypass.
    wb_en = 1'b1; wb_addr = 5'd9; Wdata = 32'hDEAD_BEEF;
    cyc();
    Wdata = 32'd5; in_valid = 1'b1; Ins = mk_r(9, 0, 2);
    cyc();
    chk("byp_on",  Rdata1,    32'd5);
    chk("byp_off", nb_Rdata1, 32'hDEAD_BEEF);

    // 3: r0 write dropped; destination / write-enable decode.
    in_valid = 1'b0; wb_addr = 5'd0; Wdata = 32'd7;
    cyc();
    wb_en = 1'b0; in_valid = 1'b1; Ins = mk_r(0, 0, 5);
    cyc();
    chk("r0_rd1", Rdata1, 32'd0);
    Ins = {JAL, 26'h0000123};
    cyc();
    chk("jal_wadr", 32'(Wadr),   32'd31);
    chk("jal_we",   32'(reg_we), 32'd1);
    Ins = mk_i(SW, 1, 2, 16'h0004);
    cyc();
    chk("sw_we", 32'(reg_we), 32'd0);
    Ins = mk_i(BEQ, 1, 2, 16'h0008);
    cyc();
    chk("beq_we", 32'(reg_we), 32'd0);
    Ins = mk_r(1, 2, 0);
    cyc();
    chk("rd0_we", 32'(reg_we), 32'd0);

    // 4: immediate extension.
    Ins = mk_i(ORI, 1, 7, 16'h8001);
    cyc();
    chk("ori_ext",  Ed32,       32'h0000_8001);
    chk("ori_wadr", 32'(Wadr),  32'd7);
    Ins = mk_i(OP_ADDI, 1, 6, 16'h8001);
    cyc();
    chk("addi_ext", Ed32, 32'hFFFF_8001);

    // 5: stall with a write-back hazard, then back-to-back accepts.
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; Ins = mk_r(9, 9, 3);
    cyc();
    chk("stall_load", Rdata1, 32'd5);
    Ins = mk_r(1, 2, 4); wb_en = 1'b1; wb_addr = 5'd9; Wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_rdy",  32'(in_ready),  32'd0);
      chk("stall_vld",  32'(out_valid), 32'd1);
      chk("stall_rd1",  Rdata1,         32'd5);
      chk("stall_wadr", 32'(Wadr),      32'd3);
    end
    wb_en = 1'b0; out_ready = 1'b1; Ins = mk_r(9, 0, 10);
    #1;
    chk("resume_rdy", 32'(in_ready), 32'd1);
    cyc();
    chk("b2b_rd1", Rdata1, 32'h77);
    chk("b2b_w10", 32'(Wadr), 32'd10);
    Ins = mk_r(9, 0, 11);
    cyc();
    chk("b2b_vld", 32'(out_valid), 32'd1);
    chk("b2b_w11", 32'(Wadr), 32'd11);
    Ins = mk_r(0, 9, 12);
    cyc();
    chk("b2b_rd2", Rdata2, 32'h77);
    chk("b2b_w12", 32'(Wadr), 32'd12);

    // Fill every register with a distinct value and read them back.
    in_valid = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i); Wdata = 32'hC0DE_0000 | 32'(i);
      cyc();
    end
    wb_en = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      in_valid = 1'b1; Ins = mk_r(i, REG_NUM - i, 1);
      cyc();
      if (i == 17) begin
        chk("fill_rd1", Rdata1, 32'hC0DE_0011);
        chk("fill_rd2", Rdata2, 32'hC0DE_000F);
      end
    end

    // 6: reset with a full slot, reset again mid-sweep, full sweep clears the file.
    out_ready = 1'b0; in_valid = 1'b1; Ins = mk_r(17, 18, 19);
    cyc();
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_vld",  32'(out_valid), 32'd0);
    chk("arst_rd1",  Rdata1,         32'd0);
    chk("arst_wadr", 32'(Wadr),      32'd0);
    chk("arst_busy", 32'(init_busy), 32'd1);
    cyc();
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("part_busy", 32'(init_busy), 32'd1);
      cyc();
    end
    RST_N = 1'b0;
    #1;
    chk("mid_busy", 32'(init_busy), 32'd1);
    chk("mid_vld",  32'(out_valid), 32'd0);
    RST_N = 1'b1;
    sweep_check("sweep2");
    read_all_zero("zero2");
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
